// File: rtl/av_config_responder_if.sv
// av_config_responder_if: serial config lines plus the decoded register-write outputs
interface av_config_responder_if;
  logic       av_config_SCLK;
  logic       av_config_SDAT_in;
  logic       av_config_SDAT_oe;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       wr_valid;
  logic       busy;
  logic       frame_err;
  modport slave (
    input  av_config_SCLK, av_config_SDAT_in,
    output av_config_SDAT_oe, reg_addr, reg_data, wr_valid, busy, frame_err
  );
  modport master (
    output av_config_SCLK, av_config_SDAT_in,
    input  av_config_SDAT_oe, reg_addr, reg_data, wr_valid, busy, frame_err
  );
endinterface

// File: rtl/av_config_responder.sv
// av_config_responder: I2C-style write-only slave decoding {addr, reg_addr|d8, d[7:0]} frames
module av_config_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic                         clk,
  input  logic                         reset_n,
  av_config_responder_if.slave         bus
);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, b1, b1_n;
  logic sc, sp, dc, dp, start, stop, rise, fall, full, in_byte, stop_err, rs_err, err_n, wr_n;
  // [1] is the synchronized level, [2] its one-cycle history
  assign sc = scl_q[1];
  assign sp = scl_q[2];
  assign dc = sda_q[1];
  assign dp = sda_q[2];
  assign start = sc && sp && dp && !dc;
  assign stop = sc && sp && !dp && dc;
  assign rise = sc && !sp;
  assign fall = !sc && sp;
  assign full = cnt == 4'd8;
  assign in_byte = (state inside {ADDR, BYTE1, BYTE2}) && !full;
  assign stop_err = (state == ADDR && cnt != 4'd0) || (state inside {ACK_A, BYTE1, ACK_1, BYTE2});
  // once BYTE2 is complete the write has already been issued
  assign rs_err = stop_err && !(state == BYTE2 && full);
  assign bus.av_config_SDAT_oe = state inside {ACK_A, ACK_1, ACK_2};
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    b1_n = b1;
    err_n = 1'b0;
    wr_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      err_n = stop_err;
    end else if (start) begin
      state_n = ADDR;
      cnt_n = 4'd0;
      err_n = rs_err;
    end else if (state == IDLE) begin
      state_n = IDLE;
    end else if (rise && in_byte) begin
      sh_n = {sh[6:0], dc};
      cnt_n = cnt + 4'd1;
      wr_n = state == BYTE2 && cnt == 4'd7;
    end else if (fall) begin
      cnt_n = full ? 4'd0 : cnt;
      b1_n = (state == BYTE1 && full) ? sh : b1;
      state_n = (state == ADDR && full) ? ((sh[7:1] == DEV_ADDR && !sh[0]) ? ACK_A : WAIT_STOP) :
                (state == BYTE1 && full) ? ACK_1 :
                (state == BYTE2 && full) ? ACK_2 :
                (state == ACK_A) ? BYTE1 :
                (state == ACK_1) ? BYTE2 :
                (state == ACK_2) ? WAIT_STOP : state;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_q <= '1;
      sda_q <= '1;
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      b1 <= '0;
      bus.wr_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.reg_addr <= '0;
      bus.reg_data <= '0;
    end else begin
      scl_q <= {scl_q[1:0], bus.av_config_SCLK};
      sda_q <= {sda_q[1:0], bus.av_config_SDAT_in};
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      b1 <= b1_n;
      bus.wr_valid <= wr_n;
      bus.frame_err <= err_n;
      if (wr_n) begin
        bus.reg_addr <= b1[7:1];
        bus.reg_data <= {b1[0], sh[6:0], dc};
      end
    end
  end
endmodule

// File: doc/av_config_responder.md
AV_CONFIG_RESPONDER -- requirements
Module: av_config_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, meaning the 7-bit I2C device address this block answers to.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port av_config_SCLK  input  1  serial clock from the configuration master, asynchronous.
REQ-005 SHALL have port av_config_SDAT_in  input  1  resolved serial data line level, asynchronous.
REQ-006 SHALL have port av_config_SDAT_oe  output  1  1 = pull the data line low; 0 = release it (open-drain).
REQ-007 SHALL have port reg_addr  output  7  register address of the last completed write.
REQ-008 SHALL have port reg_data  output  9  register data of the last completed write.
REQ-009 SHALL have port wr_valid  output  1  one-cycle strobe; reg_addr and reg_data are valid on it.
REQ-010 SHALL have port busy  output  1  high from START until STOP, or until return to IDLE.
REQ-011 SHALL have port frame_err  output  1  one-cycle strobe on an aborted or illegal frame.

Function
REQ-012 SHALL pass SCLK and SDAT_in each through a 2-flop synchronizer, then a third history flop, with identical delay on both lines.
REQ-013 SHALL detect these conditions from the synchronized lines:
- START: SDAT falls while SCLK is high.
- STOP: SDAT rises while SCLK is high.
- Sample: SCLK rising edge.
- Shift: SCLK falling edge.
REQ-014 SHALL sample data bits MSB first on each SCLK rising edge that is not part of a START or STOP.
REQ-015 SHALL implement states IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP.
REQ-016 IDLE SHALL go to ADDR on START; all other SCLK/SDAT activity in IDLE SHALL be ignored.
REQ-017 ADDR SHALL collect 8 bits (7-bit address plus R/W). On the SCLK falling edge after bit 8, the next state SHALL be:
- ACK_A, with SDAT_oe=1, when the address equals DEV_ADDR and R/W=0;
- WAIT_STOP, with SDAT_oe kept 0 (NACK), otherwise.
REQ-018 ACK_A, ACK_1 and ACK_2 SHALL hold SDAT_oe=1 until the next SCLK falling edge, then release it. ACK_A SHALL then enter BYTE1, ACK_1 SHALL enter BYTE2, and ACK_2 SHALL enter WAIT_STOP.
REQ-019 Byte fields SHALL be mapped as follows:
- BYTE1 = {reg_addr[6:0], reg_data[8]}.
- BYTE2 = reg_data[7:0].
- Both SHALL be shifted into internal registers, not into the outputs.
REQ-020 SHALL update reg_addr and reg_data together and pulse wr_valid for exactly one cycle. This SHALL happen on the clk cycle after the SCLK rising edge that samples bit 8 of BYTE2 is detected.
REQ-021 In WAIT_STOP, any further data byte SHALL be NACKed (SDAT_oe stays 0), and no wr_valid SHALL be issued.
REQ-022 A START in any non-IDLE state (repeated start) SHALL discard partial bits and go to ADDR. If this happens before wr_valid for the current frame, frame_err SHALL pulse.
REQ-023 A STOP in any state SHALL go to IDLE and release SDAT_oe. frame_err SHALL pulse if the STOP arrives in ADDR (at least 1 bit received), ACK_A, BYTE1, ACK_1 or BYTE2.
REQ-024 A STOP in WAIT_STOP or ACK_2 SHALL be a clean end of frame with no error.
REQ-025 If START/STOP and a Sample are detected in the same cycle, START/STOP SHALL take priority and the bit SHALL be discarded.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 SHALL never drive SDAT_oe=1 while SCLK is high, except during an ACK bit period.
REQ-028 Latency from line edge to internal detection SHALL be 3 clk cycles; the master's SCLK half-period SHALL be at least 8 clk cycles.

Reset
REQ-029 While reset_n=0 at a clk edge, the following SHALL hold on the next cycle:
- state=IDLE;
- SDAT_oe=0, wr_valid=0, frame_err=0, busy=0;
- reg_addr=7'h00, reg_data=9'h000;
- synchronizer flops = 1 (idle bus level).
REQ-030 Reset asserted mid-frame SHALL abort the frame silently, with no wr_valid and no frame_err. After reset the block SHALL wait for a fresh START.

Verification
REQ-031 Write frame 0x34, 0x1E, 0x00 then STOP -> three ACKs; wr_valid pulses once with reg_addr=7'h0F, reg_data=9'h000; no frame_err.
REQ-032 Write frame 0x34, 0x09, 0x01 -> reg_addr=7'h04, reg_data=9'h101; a second frame 0x34, 0x0C, 0x02 -> reg_addr=7'h06, reg_data=9'h002; two wr_valid pulses total.
REQ-033 Address byte 0x36 (mismatch) or 0x35 (read) -> SDAT_oe stays 0 through the ACK slot; no wr_valid; STOP gives no frame_err.
REQ-034 STOP after 0x34, 0x1E only -> frame_err pulses once; wr_valid never asserted; busy=0 after STOP; reg outputs unchanged.
REQ-035 Repeated START after 4 bits of BYTE2, then full frame 0x34, 0x12, 0x01 -> one frame_err, then wr_valid with reg_addr=7'h09, reg_data=9'h001.
REQ-036 reset_n=0 during BYTE1 -> SDAT_oe=0 and busy=0 on the next cycle; a subsequent valid frame is accepted normally.
